exe_muldiv: RTL and testbench

Iterative multiply/divide unit in the EXE stage, the consumer side of the ID/EXE pipeline register. It takes the registered operands and EXE command for MULT/MULTU/DIV/DIVU and computes the result over multiple cycles into architectural HI/LO registers. While it works, it holds the pipeline through `stall`. Results are read by MFHI/MFLO through the `hi`/`lo` outputs.

---
 rtl/exe_muldiv.sv | 179 +++++++++++++++++
 tb/tb_exe_muldiv.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/exe_muldiv.sv
// Iterative multiply/divide unit for the EXE stage.
// MULT/MULTU use radix-2 shift-add (LSB first), DIV/DIVU use restoring
// division (MSB first). Both run WORD_LEN iterations on magnitudes, then a
// single SIGN cycle applies the two's-complement fix and writes HI/LO.
//
// Handshake: a command is accepted on an edge where the unit is IDLE, start
// is high and flush is low. The producer must hold start/op/a/b until then;
// stall (= busy | start) freezes the upstream pipeline so this happens for
// free. done pulses for one cycle after HI/LO change, and stall is already
// low in that cycle.
module exe_muldiv #(
  parameter int WORD_LEN = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [1:0]          op,
  input  logic [WORD_LEN-1:0] a,
  input  logic [WORD_LEN-1:0] b,
  input  logic                flush,
  output logic                busy,
  output logic                stall,
  output logic                done,
  output logic                div_zero,
  output logic [WORD_LEN-1:0] hi,
  output logic [WORD_LEN-1:0] lo,
  output logic [1:0]          state_dbg
);

  localparam int W     = WORD_LEN;
  localparam int CNT_W = $clog2(WORD_LEN);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WORD_LEN - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    SIGN = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q;
  logic             is_div_q;    // latched op[1]
  logic             neg_q;       // product/quotient is negative
  logic             rem_neg_q;   // remainder takes the dividend's sign
  logic [W-1:0]     opnd_q;      // multiplicand (mul) or divisor (div), magnitude
  // Shared accumulator. Multiply: [2W-1:0] is {partial product, multiplier}.
  // Divide: [2W:W] is the partial remainder, [W-1:0] the dividend/quotient.
  logic [2*W:0]     acc_q;

  logic             accept;
  logic             in_signed;
  logic [W-1:0]     a_mag, b_mag;
  logic [W:0]       mul_sum;
  logic [W:0]       div_shift;
  logic [W:0]       div_diff;
  logic             div_ge;
  logic [2*W:0]     acc_step;
  logic [2*W-1:0]   prod_fix;
  logic [W-1:0]     quo_fix;
  logic [W-1:0]     rem_fix;
  logic             divisor_zero;
  logic             unused_acc_top;

  assign accept    = (state_q == IDLE) && start && !flush;
  assign in_signed = ~op[0];
  assign busy      = (state_q != IDLE);
  assign stall     = busy | start;
  assign state_dbg = state_q;

  // The remainder never reaches WORD_LEN+1 significant bits, so its top bit
  // is carried only to keep the register at its natural width.
  assign unused_acc_top = acc_q[2*W];

  // Operand magnitudes for signed ops; raw values for unsigned ops.
  always_comb begin
    a_mag = a;
    b_mag = b;
    if (in_signed && a[W-1]) a_mag = -a;
    if (in_signed && b[W-1]) b_mag = -b;
  end

  // One iteration of shift-add multiply or restoring divide.
  always_comb begin
    mul_sum   = {1'b0, acc_q[2*W-1:W]} + {1'b0, (acc_q[0] ? opnd_q : {W{1'b0}})};
    div_shift = {acc_q[2*W-1:W], acc_q[W-1]};
    div_diff  = div_shift - {1'b0, opnd_q};
    div_ge    = (div_shift >= {1'b0, opnd_q});
    if (is_div_q)
      acc_step = {(div_ge ? div_diff : div_shift), acc_q[W-2:0], div_ge};
    else
      acc_step = {1'b0, mul_sum, acc_q[W-1:1]};
  end

  // Sign correction applied in the SIGN cycle. A zero divisor yields a
  // remainder equal to |a|; with the dividend's sign restored that is a.
  always_comb begin
    prod_fix     = neg_q ? -acc_q[2*W-1:0] : acc_q[2*W-1:0];
    quo_fix      = neg_q ? -acc_q[W-1:0] : acc_q[W-1:0];
    rem_fix      = rem_neg_q ? -acc_q[2*W-1:W] : acc_q[2*W-1:W];
    divisor_zero = (opnd_q == {W{1'b0}});
  end

  // Next-state logic: flush aborts CALC/SIGN and blocks acceptance in IDLE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (accept) state_d = CALC;
      CALC: begin
        if (flush)                 state_d = IDLE;
        else if (cnt_q == CNT_LAST) state_d = SIGN;
      end
      SIGN:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // Datapath, counter and architectural HI/LO.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q     <= '0;
      is_div_q  <= 1'b0;
      neg_q     <= 1'b0;
      rem_neg_q <= 1'b0;
      opnd_q    <= '0;
      acc_q     <= '0;
      hi        <= '0;
      lo        <= '0;
      done      <= 1'b0;
      div_zero  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state_q)
        IDLE: begin
          if (accept) begin
            is_div_q  <= op[1];
            neg_q     <= in_signed & (a[W-1] ^ b[W-1]);
            rem_neg_q <= in_signed & a[W-1];
            cnt_q     <= '0;
            div_zero  <= 1'b0;
            if (op[1]) begin
              opnd_q <= b_mag;
              acc_q  <= {{(W+1){1'b0}}, a_mag};
            end else begin
              opnd_q <= a_mag;
              acc_q  <= {{(W+1){1'b0}}, b_mag};
            end
          end
        end
        CALC: begin
          if (!flush) begin
            acc_q <= acc_step;
            cnt_q <= cnt_q + 1'b1;
          end
        end
        SIGN: begin
          if (!flush) begin
            done <= 1'b1;
            if (is_div_q) begin
              hi       <= rem_fix;
              lo       <= divisor_zero ? {W{1'b1}} : quo_fix;
              div_zero <= divisor_zero;
            end else begin
              hi <= prod_fix[2*W-1:W];
              lo <= prod_fix[W-1:0];
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_exe_muldiv.sv
// Directed and randomized bench for exe_muldiv with an arithmetic reference
// model and an expected-result queue.
module tb_exe_muldiv;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         start = 1'b0;
  logic         flush = 1'b0;
  logic [1:0]   op = 2'd0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         busy, stall, done, div_zero;
  logic [W-1:0] hi, lo;
  logic [1:0]   state_dbg;

  int checks = 0;
  int errors = 0;

  logic [W-1:0] exp_q[$];       // pushed as hi, lo, div_zero
  logic [W-1:0] exp_hi = '0;
  logic [W-1:0] exp_lo = '0;
  logic         exp_dz = 1'b0;

  // Clock
  always #5 clk = ~clk;

  exe_muldiv #(.WORD_LEN(W)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .op       (op),
    .a        (a),
    .b        (b),
    .flush    (flush),
    .busy     (busy),
    .stall    (stall),
    .done     (done),
    .div_zero (div_zero),
    .hi       (hi),
    .lo       (lo),
    .state_dbg(state_dbg)
  );

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // Reference model: plain 64-bit and integer arithmetic.
  task automatic model(input logic [1:0] m_op, input logic [W-1:0] ma, input logic [W-1:0] mb);
    logic [2*W-1:0] p;
    logic [W-1:0]   mh, ml;
    logic           mdz;
    int             sa, sb;
    mdz = 1'b0;
    p   = '0;
    sa  = ma;
    sb  = mb;
    case (m_op)
      2'd0: begin
        p  = {{W{ma[W-1]}}, ma} * {{W{mb[W-1]}}, mb};
        mh = p[2*W-1:W];
        ml = p[W-1:0];
      end
      2'd1: begin
        p  = {{W{1'b0}}, ma} * {{W{1'b0}}, mb};
        mh = p[2*W-1:W];
        ml = p[W-1:0];
      end
      2'd2: begin
        if (mb == 0) begin
          ml = '1; mh = ma; mdz = 1'b1;
        end else if (ma == 32'h8000_0000 && mb == 32'hFFFF_FFFF) begin
          ml = 32'h8000_0000; mh = '0;
        end else begin
          ml = sa / sb;
          mh = sa % sb;
        end
      end
      default: begin
        if (mb == 0) begin
          ml = '1; mh = ma; mdz = 1'b1;
        end else begin
          ml = ma / mb;
          mh = ma % mb;
        end
      end
    endcase
    exp_q.push_back(mh);
    exp_q.push_back(ml);
    exp_q.push_back({{(W-1){1'b0}}, mdz});
  endtask

  // Issue one command and watch 40 cycles. flush_k > 0 raises flush in
  // cycle flush_k after the start cycle; glitch re-pulses start mid-CALC.
  task automatic run_op(input string tag, input logic [1:0] t_op, input logic [W-1:0] ta,
                        input logic [W-1:0] tb_v, input int flush_k, input bit glitch);
    int done_k = 0;
    int done_n = 0;
    int stall_n = 0;
    if (flush_k == 0) model(t_op, ta, tb_v);
    @(negedge clk);
    op = t_op; a = ta; b = tb_v; start = 1'b1;
    #1;
    check({tag, ".stall_in_start_cycle"}, {31'b0, stall}, 32'd1);
    @(negedge clk);
    start = 1'b0; op = 2'($urandom_range(0, 3)); a = $urandom; b = $urandom;
    for (int k = 1; k <= 40; k++) begin
      if (k > 1) @(negedge clk);
      if (done) begin
        done_n++;
        if (done_k == 0) done_k = k;
      end
      if (stall) stall_n++;
      if (flush_k > 0 && k == flush_k + 1) begin
        check({tag, ".busy_after_flush"}, {31'b0, busy}, 32'd0);
        flush = 1'b0;
      end
      if (flush_k > 0 && k == flush_k) flush = 1'b1;
      if (glitch && k == 5) begin
        start = 1'b1; op = t_op ^ 2'b01; a = ~ta; b = tb_v + 32'd3;
      end
      if (glitch && k == 6) start = 1'b0;
    end
    if (flush_k > 0) begin
      check({tag, ".no_done"}, 32'(done_n), 32'd0);
      check({tag, ".hi_kept"}, hi, exp_hi);
      check({tag, ".lo_kept"}, lo, exp_lo);
      check({tag, ".div_zero_kept"}, {31'b0, div_zero}, {31'b0, exp_dz});
    end else begin
      exp_hi = exp_q.pop_front();
      exp_lo = exp_q.pop_front();
      exp_dz = exp_q.pop_front() != 0;
      check({tag, ".done_cycle"}, 32'(done_k), 32'd34);
      check({tag, ".done_width"}, 32'(done_n), 32'd1);
      check({tag, ".stall_cycles"}, 32'(stall_n), 32'd33);
      check({tag, ".hi"}, hi, exp_hi);
      check({tag, ".lo"}, lo, exp_lo);
      check({tag, ".div_zero"}, {31'b0, div_zero}, {31'b0, exp_dz});
    end
  endtask

  initial begin
    // Reset state
    repeat (3) @(negedge clk);
    check("reset.hi", hi, '0);
    check("reset.lo", lo, '0);
    check("reset.busy", {31'b0, busy}, 32'd0);
    check("reset.done", {31'b0, done}, 32'd0);
    check("reset.div_zero", {31'b0, div_zero}, 32'd0);
    check("reset.stall", {31'b0, stall}, 32'd0);
    rst = 1'b1;

    // Directed arithmetic
    run_op("multu_max", 2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 1'b0);
    check("multu_max.hi_const", hi, 32'hFFFF_FFFE);
    check("multu_max.lo_const", lo, 32'h0000_0001);
    run_op("mult_neg", 2'd0, 32'hFFFF_FFFD, 32'd7, 0, 1'b0);
    check("mult_neg.lo_const", lo, 32'hFFFF_FFEB);
    run_op("div_neg", 2'd2, 32'hFFFF_FFF9, 32'd2, 0, 1'b0);
    check("div_neg.lo_const", lo, 32'hFFFF_FFFD);
    run_op("divu", 2'd3, 32'd100, 32'd7, 0, 1'b0);
    check("divu.lo_const", lo, 32'd14);
    run_op("div_zero", 2'd2, 32'd5, 32'd0, 0, 1'b0);
    check("div_zero.flag_const", {31'b0, div_zero}, 32'd1);
    run_op("div_ovf", 2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 0, 1'b0);
    check("div_ovf.flag_const", {31'b0, div_zero}, 32'd0);

    // Control interactions
    run_op("start_glitch", 2'd1, 32'h1234_5678, 32'h0000_9ABC, 0, 1'b1);
    run_op("flush_calc10", 2'd0, 32'h0F0F_0F0F, 32'h7777_7777, 10, 1'b0);

    // Asynchronous reset mid-CALC
    @(negedge clk);
    op = 2'd1; a = 32'hDEAD_BEEF; b = 32'h0000_0101; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    #1 rst = 1'b0;
    #1;
    check("async_rst.hi", hi, '0);
    check("async_rst.lo", lo, '0);
    check("async_rst.busy", {31'b0, busy}, 32'd0);
    check("async_rst.done", {31'b0, done}, 32'd0);
    check("async_rst.div_zero", {31'b0, div_zero}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    exp_hi = '0; exp_lo = '0; exp_dz = 1'b0;
    run_op("after_rst", 2'd3, 32'hFFFF_FFF0, 32'd9, 0, 1'b0);

    // Randomized operations with edge-value bias
    for (int i = 0; i < 16; i++) begin
      logic [1:0]   r_op;
      logic [W-1:0] r_a, r_b;
      r_op = 2'($urandom_range(0, 3));
      r_a  = $urandom;
      r_b  = $urandom;
      if ($urandom_range(0, 5) == 0) r_b = '0;
      if ($urandom_range(0, 5) == 0) r_a = 32'h8000_0000;
      if ($urandom_range(0, 5) == 0) r_b = 32'($urandom_range(1, 15));
      if ($urandom_range(0, 7) == 0) r_b = 32'hFFFF_FFFF;
      run_op("random", r_op, r_a, r_b, 0, 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
